// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
//
// Operand/result bundle for serial_adder_ctrl.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its payload stable from the
// cycle valid rises until that edge. The consumer may raise or drop ready at any
// time. Valid is never withdrawn by the producer before the transfer.
//
// Signals:
//   in_valid, in_ready   operand channel handshake
//   a, b                 WIDTH-bit operands
//   cin                  carry-in (add) / borrow-in (subtract)
//   sub                  0 = add, 1 = subtract
//   acc_sel              take A from the accumulator (SERIAL_ADDER_ACCUM_EN only)
//   out_valid, out_ready result channel handshake
//   sum, cout, ovf       result, final carry (sub: 1 = no borrow), signed overflow
//
// Modports:
//   master  operand producer / result consumer
//   slave   the adder itself
//
// Optional feature macro: SERIAL_ADDER_ACCUM_EN
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef SERIAL_ADDER_ACCUM_EN
    logic             acc_sel;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_ACCUM_EN
    modport master (
        output in_valid, a, b, cin, sub, acc_sel, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, acc_sel, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Multi-cycle WIDTH-bit add/subtract. One DIGIT-wide full-adder slice is reused
// N = WIDTH/DIGIT times, with a single carry flip-flop chained across cycles.
// Subtraction is A + ~B + ~bin, so cout = 1 means "no borrow".
//
// FSM: IDLE (accept operands) -> RUN (N slice cycles) -> DONE (hold result
// until taken) -> IDLE. out_valid rises exactly N edges after the accepting
// edge; with out_ready held high one operation completes every N+2 cycles.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   bus        serial_adder_ctrl_if.slave (operand and result handshakes)
//   busy       high while in RUN
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Optional feature macro: SERIAL_ADDER_ACCUM_EN
//   When defined, an internal WIDTH-bit accumulator captures sum on every
//   output handshake, and bus.acc_sel = 1 at operand accept makes A come from
//   the accumulator instead of bus.a.
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Elaboration-time parameter checks.
    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder_ctrl: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Datapath registers.
    logic [WIDTH-1:0] a_q;        // remaining digits of A, consumed from the LSB
    logic [WIDTH-1:0] b_q;        // remaining digits of effective B
    logic [WIDTH-1:0] res_q;      // result, filled from the MSB side
    logic             carry_q;    // carry chained between slice cycles
    logic [CNT_W-1:0] cnt_q;      // RUN cycles completed
    logic             sign_a_q;   // sign of A as accepted
    logic             sign_b_q;   // sign of effective B as accepted
    logic             cout_q;     // final carry, held through DONE and beyond
    logic             ovf_q;      // signed overflow, held through DONE and beyond

    // FSM strobes.
    logic accept;
    logic step;
    logic last_step;
    logic release_res;

    // Operand sources at accept.
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_eff;

    // Shared slice.
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_ADDER_ACCUM_EN
    logic [WIDTH-1:0] acc_q;
    assign a_src = bus.acc_sel ? acc_q : bus.a;
`else
    assign a_src = bus.a;
`endif

    assign b_eff = bus.b ^ {WIDTH{bus.sub}};

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        step          = 1'b0;
        last_step     = 1'b0;
        release_res   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    last_step = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // No accept here: the operand side reopens one cycle later.
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    release_res = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    assign slice = {1'b0, a_q[DIGIT-1:0]}
                 + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};

    // New digit enters at the top; after N steps digit 0 has reached the LSB.
    if (DIGIT == WIDTH) begin : g_res_full
        assign res_shift = slice[DIGIT-1:0];
    end else begin : g_res_part
        assign res_shift = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= a_src;
            b_q      <= b_eff;
            carry_q  <= bus.cin ^ bus.sub;
            cnt_q    <= '0;
            sign_a_q <= a_src[WIDTH-1];
            sign_b_q <= b_eff[WIDTH-1];
        end else if (step) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= res_shift;
            carry_q <= slice[DIGIT];
            cnt_q   <= cnt_q + 1'b1;
            if (last_step) begin
                // slice[DIGIT-1] is the final result MSB being shifted in.
                cout_q <= slice[DIGIT];
                ovf_q  <= (sign_a_q == sign_b_q) && (slice[DIGIT-1] != sign_a_q);
            end
        end
    end

`ifdef SERIAL_ADDER_ACCUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (release_res) begin
            acc_q <= res_q;
        end
    end
`else
    logic unused_release;
    assign unused_release = release_res;
`endif

    assign bus.sum  = res_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// dut0: WIDTH=8, DIGIT=1.  dut1: WIDTH=8, DIGIT=4.
// Expected results come from integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic       busy0, busy1;
    logic [1:0] state_dbg0, state_dbg1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_acc = '0;
    logic [9:0]   exp_q[$];   // {cout, ovf, sum}

    serial_adder_ctrl_if #(.WIDTH(W)) bus0 ();
    serial_adder_ctrl_if #(.WIDTH(W)) bus1 ();

    serial_adder_ctrl #(.WIDTH(W), .DIGIT(1)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0.slave),
        .busy      (busy0),
        .state_dbg (state_dbg0)
    );

    serial_adder_ctrl #(.WIDTH(W), .DIGIT(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1.slave),
        .busy      (busy1),
        .state_dbg (state_dbg1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_acc = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [9:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rcin, input logic rsub);
        int ua, ub, sa, sb, full, sres;
        logic [W-1:0] s;
        logic c, o;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        if (!rsub) begin
            full = ua + ub + int'(rcin);
            c    = (full > 255);
            sres = sa + sb + int'(rcin);
        end else begin
            full = ua - ub - int'(rcin);
            c    = (full >= 0);
            sres = sa - sb - int'(rcin);
        end
        s = full[W-1:0];
        o = (sres > 127) || (sres < -128);
        return {c, o, s};
    endfunction

    // ---------------- driver tasks (dut0) ----------------
    // Presents one operand bundle, returns when out_valid is seen (result not taken).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input logic tacc,
                         output int lat, output int busy_n, output bit tmo);
        int t;
        tmo = 1'b0;
        t = 0;
        while (!bus0.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) tmo = 1'b1;
        bus0.a        = ta;
        bus0.b        = tb_v;
        bus0.cin      = tcin;
        bus0.sub      = tsub;
`ifdef SERIAL_ADDER_ACCUM_EN
        bus0.acc_sel  = tacc;
`else
        if (tacc) tmo = 1'b1;
`endif
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!bus0.out_valid && lat < 50) begin
            busy_n += int'(busy0);
            tick();
            lat++;
        end
        if (lat >= 50) tmo = 1'b1;
`ifdef SERIAL_ADDER_ACCUM_EN
        bus0.acc_sel = 1'b0;
`endif
    endtask

    task automatic take_result(input logic [W-1:0] exp_s);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        model_acc = exp_s;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus0.in_ready, bus0.out_valid, busy0);
        end
        checks++;
        if (bus0.sum !== 8'h00 || bus0.cout !== 1'b0 || bus0.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b ovf=%b, want 00 0 0",
                     bus0.sum, bus0.cout, bus0.ovf);
        end
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus1.in_ready, bus1.out_valid, busy1);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] vb[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
        logic         vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0]   ve[4] = '{{1'b0, 1'b1, 8'h96}, {1'b1, 1'b0, 8'h00},
                                {1'b0, 1'b0, 8'hF0}, {1'b1, 1'b1, 8'h7F}};
        int lat, bn;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, vs[i], 1'b0, lat, bn, tmo);
            checks++;
            if (tmo || {bus0.cout, bus0.ovf, bus0.sum} !== ve[i]) begin
                errors++;
                $display("FAIL directed_%0d: cout/ovf/sum=%b/%b/%h tmo=%0d, want %b/%b/%h",
                         i, bus0.cout, bus0.ovf, bus0.sum, tmo, ve[i][9], ve[i][8], ve[i][7:0]);
            end
            checks++;
            if (lat != 8 || bn != 8) begin
                errors++;
                $display("FAIL directed_timing_%0d: latency=%0d busy_cycles=%0d, want 8 8",
                         i, lat, bn);
            end
            take_result(ve[i][7:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, a_used;
        logic rc, rs, racc;
        logic [9:0] e;
        int lat, bn;
        bit tmo;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_ACCUM_EN
            racc = 1'($urandom_range(0, 1));
`else
            racc = 1'b0;
`endif
            a_used = racc ? model_acc : ra;
            e = ref_op(a_used, rb, rc, rs);
            do_op(ra, rb, rc, rs, racc, lat, bn, tmo);
            checks++;
            if (tmo || lat != 8 || {bus0.cout, bus0.ovf, bus0.sum} !== e) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b acc=%b got %b/%b/%h lat=%0d, want %b/%b/%h lat=8",
                         i, a_used, rb, rc, rs, racc, bus0.cout, bus0.ovf, bus0.sum, lat,
                         e[9], e[8], e[7:0]);
            end
            take_result(e[7:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] e;
        int lat, bn, bad;
        bit tmo;
        e = ref_op(8'hC3, 8'h7E, 1'b1, 1'b1);
        do_op(8'hC3, 8'h7E, 1'b1, 1'b1, 1'b0, lat, bn, tmo);
        bad = tmo ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0 ||
                {bus0.cout, bus0.ovf, bus0.sum} !== e) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles, last out_valid=%b in_ready=%b result=%b/%b/%h, want 1 0 %b/%b/%h",
                     bad, bus0.out_valid, bus0.in_ready, bus0.cout, bus0.ovf, bus0.sum,
                     e[9], e[8], e[7:0]);
        end
        take_result(e[7:0]);
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0",
                     bus0.in_ready, bus0.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        bus0.a = 8'h5A; bus0.b = 8'h3C; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus0.in_valid = 1'b1;
        tick();                 // accepting edge, now in 1st RUN cycle
        bus0.in_valid = 1'b0;
        tick();                 // 2nd RUN cycle
        tick();                 // 3rd RUN cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_acc = '0;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || busy0 !== 1'b0 ||
            bus0.sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b busy=%b sum=%h, want 0 1 0 00",
                     bus0.out_valid, bus0.in_ready, busy0, bus0.sum);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus0.out_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_output: out_valid seen %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_digit4();
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vs[3];
        logic         vc[3];
        logic [9:0] e;
        int lat;
        va[0] = 8'h5A; vb[0] = 8'h3C; vs[0] = 1'b0; vc[0] = 1'b0;
        for (int i = 1; i < 3; i++) begin
            va[i] = W'($urandom_range(0, 255));
            vb[i] = W'($urandom_range(0, 255));
            vs[i] = 1'($urandom_range(0, 1));
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 3; i++) begin
            e = ref_op(va[i], vb[i], vc[i], vs[i]);
            bus1.a = va[i]; bus1.b = vb[i]; bus1.cin = vc[i]; bus1.sub = vs[i];
            bus1.in_valid = 1'b1;
            tick();
            bus1.in_valid = 1'b0;
            lat = 0;
            while (!bus1.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != 2 || {bus1.cout, bus1.ovf, bus1.sum} !== e) begin
                errors++;
                $display("FAIL digit4_%0d: lat=%0d result=%b/%b/%h, want lat=2 %b/%b/%h",
                         i, lat, bus1.cout, bus1.ovf, bus1.sum, e[9], e[8], e[7:0]);
            end
            bus1.out_ready = 1'b1;
            tick();
            bus1.out_ready = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb;
        logic rc, rs;
        logic [9:0] got;
        int cyc, n_acc, n_out, last_out, gap_bad;
        bit accept_now;
        exp_q.delete();
        cyc = 0; n_acc = 0; n_out = 0; last_out = -1; gap_bad = 0;
        ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));   rs = 1'($urandom_range(0, 1));
        bus0.a = ra; bus0.b = rb; bus0.cin = rc; bus0.sub = rs;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        while (n_out < 4 && cyc < 200) begin
            if (bus0.out_valid === 1'b1) begin
                got = {bus0.cout, bus0.ovf, bus0.sum};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: result %h with empty expected queue", got);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got %b/%b/%h, want %b/%b/%h", n_out,
                                 got[9], got[8], got[7:0], exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
                    end
                    model_acc = exp_q[0][7:0];
                    void'(exp_q.pop_front());
                end
                if (last_out >= 0 && cyc - last_out != 10) gap_bad++;
                last_out = cyc;
                n_out++;
            end
            accept_now = (bus0.in_ready === 1'b1) && bus0.in_valid && (n_acc < 4);
            if (accept_now) exp_q.push_back(ref_op(ra, rb, rc, rs));
            tick();
            cyc++;
            if (accept_now) begin
                n_acc++;
                ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));   rs = 1'($urandom_range(0, 1));
                bus0.a = ra; bus0.b = rb; bus0.cin = rc; bus0.sub = rs;
                if (n_acc >= 4) bus0.in_valid = 1'b0;
            end
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        checks++;
        if (n_out != 4 || gap_bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_throughput: results=%0d bad_gaps=%0d leftover=%0d, want 4 0 0 (period 10)",
                     n_out, gap_bad, exp_q.size());
        end
        tick();
    endtask

`ifdef SERIAL_ADDER_ACCUM_EN
    task automatic test_accum();
        int lat, bn;
        bit tmo;
        do_op(8'h05, 8'h00, 1'b0, 1'b0, 1'b0, lat, bn, tmo);
        take_result(8'h05);
        do_op(8'hE7, 8'h03, 1'b0, 1'b0, 1'b1, lat, bn, tmo);
        checks++;
        if (tmo || bus0.sum !== 8'h08) begin
            errors++;
            $display("FAIL accum: sum=%h tmo=%0d, want 08", bus0.sum, tmo);
        end
        take_result(8'h08);
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
`ifdef SERIAL_ADDER_ACCUM_EN
        bus0.acc_sel = 1'b0;
        bus1.acc_sel = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_digit4();
        test_back_to_back();
`ifdef SERIAL_ADDER_ACCUM_EN
        test_accum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
